and_tree_stim_ctrl: RTL and testbench

//  Clocked sequencer driving N-input vectors into a co-simulated asynchronous AND-tree (prsim side).
//  Per vector: drives inputs, waits for the tree output z to settle, checks z against &vector,

---
 rtl/and_tree_stim_pkg.sv | 19 +
 rtl/and_tree_sync.sv | 20 ++
 rtl/and_tree_stim_ctrl.sv | 154 +++++++++++++++
 tb/tb_and_tree_stim_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/and_tree_stim_pkg.sv
// Shared types for the AND-tree stimulus controller.
// FSM state encoding and result codes.
package and_tree_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CODE_OK      = 2'd0,
        CODE_TIMEOUT = 2'd1,
        CODE_GLITCH  = 2'd2,
        CODE_RSVD    = 2'd3
    } resp_code_t;

endpackage

// File: rtl/and_tree_sync.sv
// Multi-flop synchroniser bringing the asynchronous tree output into clk.
module and_tree_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s <= '0;
        else     s <= {s[STAGES-2:0], d};
    end

    assign q = s[STAGES-1];

endmodule

// File: rtl/and_tree_stim_ctrl.sv
// Sequencer driving vectors into an async AND-tree and timing its settle.
// Define AND_TREE_STIM_CTRL_STATS_EN to add saturating pass/fail/glitch counters.
module and_tree_stim_ctrl
    import and_tree_stim_pkg::*;
#(
    parameter  int N_IN        = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int STABLE_CYC  = 2,
    parameter  int TIMEOUT     = 16,
    localparam int LAT_W       = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N_IN-1:0]  req_vec,
    output logic [N_IN-1:0]  drv_vec,
    input  logic             dut_z,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_ok,
    output logic [1:0]       resp_code,
    output logic [LAT_W-1:0] resp_lat
`ifdef AND_TREE_STIM_CTRL_STATS_EN
    ,
    output logic [15:0]      stat_pass,
    output logic [15:0]      stat_fail,
    output logic [15:0]      stat_glitch
`endif
);

    localparam logic [LAT_W-1:0] STAB_MAX = LAT_W'(STABLE_CYC);
    localparam logic [LAT_W-1:0] TO_MAX   = LAT_W'(TIMEOUT);

    state_t           state;
    logic [N_IN-1:0]  vec;
    logic             exp_z;
    logic             seen;
    logic             glitch;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] stab_cnt;
    logic [LAT_W-1:0] win_lat;
    logic             z_s;

    and_tree_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dut_z),
        .q   (z_s)
    );

    logic             match;
    logic             glitch_now;
    logic [LAT_W-1:0] lat_nxt;
    logic [LAT_W-1:0] stab_nxt;

    assign match      = (z_s == exp_z);
    assign glitch_now = glitch | (seen & ~match);
    assign lat_nxt    = lat_cnt + LAT_W'(1);
    assign stab_nxt   = stab_cnt + LAT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            vec        <= '0;
            exp_z      <= 1'b0;
            seen       <= 1'b0;
            glitch     <= 1'b0;
            lat_cnt    <= '0;
            stab_cnt   <= '0;
            win_lat    <= '0;
            req_ready  <= 1'b0;
            drv_vec    <= '0;
            resp_valid <= 1'b0;
            resp_ok    <= 1'b0;
            resp_code  <= CODE_OK;
            resp_lat   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        vec       <= req_vec;
                        exp_z     <= &req_vec;
                        req_ready <= 1'b0;
                        state     <= ST_DRIVE;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    drv_vec  <= vec;
                    lat_cnt  <= '0;
                    stab_cnt <= '0;
                    seen     <= 1'b0;
                    glitch   <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    lat_cnt <= lat_nxt;
                    if (match) begin
                        seen     <= 1'b1;
                        stab_cnt <= stab_nxt;
                        if (stab_cnt == '0) win_lat <= lat_cnt;
                    end else begin
                        stab_cnt <= '0;
                        if (seen) glitch <= 1'b1;
                    end
                    // A window completing on the last allowed cycle still counts as OK
                    if (match && stab_nxt == STAB_MAX) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_ok    <= 1'b1;
                        resp_code  <= CODE_OK;
                        resp_lat   <= (stab_cnt == '0) ? lat_cnt : win_lat;
                    end else if (lat_nxt == TO_MAX) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_ok    <= 1'b0;
                        resp_code  <= glitch_now ? CODE_GLITCH : CODE_TIMEOUT;
                        resp_lat   <= TO_MAX;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef AND_TREE_STIM_CTRL_STATS_EN
    logic hs;
    assign hs = resp_valid & resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pass   <= '0;
            stat_fail   <= '0;
            stat_glitch <= '0;
        end else if (hs) begin
            if (resp_ok && stat_pass != 16'hFFFF)
                stat_pass <= stat_pass + 16'd1;
            if (!resp_ok && stat_fail != 16'hFFFF)
                stat_fail <= stat_fail + 16'd1;
            if (resp_code == CODE_GLITCH && stat_glitch != 16'hFFFF)
                stat_glitch <= stat_glitch + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_and_tree_stim_ctrl.sv
// Directed bench: tree modelled as z = &drv_vec delayed 3 clk cycles,
// with an override to hold z low or inject a one-cycle pulse.
module tb_and_tree_stim_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_vec;
    logic [3:0] drv_vec;
    logic       dut_z;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_ok;
    logic [1:0] resp_code;
    logic [4:0] resp_lat;
`ifdef AND_TREE_STIM_CTRL_STATS_EN
    logic [15:0] stat_pass;
    logic [15:0] stat_fail;
    logic [15:0] stat_glitch;
`endif

    and_tree_stim_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vec    (req_vec),
        .drv_vec    (drv_vec),
        .dut_z      (dut_z),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_ok    (resp_ok),
        .resp_code  (resp_code),
        .resp_lat   (resp_lat)
`ifdef AND_TREE_STIM_CTRL_STATS_EN
        ,
        .stat_pass   (stat_pass),
        .stat_fail   (stat_fail),
        .stat_glitch (stat_glitch)
`endif
    );

    always #5 clk = ~clk;

    logic [2:0] pipe = '0;
    logic       z_force_en = 1'b0;
    logic       z_force_val = 1'b0;
    int         cyc = 0;

    always @(posedge clk) begin
        pipe <= {pipe[1:0], &drv_vec};
        cyc  <= cyc + 1;
    end

    assign dut_z = z_force_en ? z_force_val : pipe[2];

    int n_chk = 0;
    int n_pass = 0;
    int t_acc = 0;
    logic [3:0] last_vec = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", tag, got, want);
    endtask

    task automatic send(input logic [3:0] v);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_wait", 32'd0, 32'd1);
        req_vec   = v;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        t_acc     = cyc;
        req_valid = 1'b0;
        check("drv_before", 32'(drv_vec), 32'(last_vec));
        @(posedge clk);
        #1;
        check("drv_vec", 32'(drv_vec), 32'(v));
        last_vec = v;
    endtask

    task automatic get_resp(input logic ok, input logic [1:0] code,
                            input logic [4:0] lat, input int cyc_exp,
                            input int hold);
        int n = 0;
        @(negedge clk);
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            check("resp_wait", 32'd0, 32'd1);
        end else begin
            check("resp_cyc", 32'(cyc - t_acc), 32'(cyc_exp));
            check("resp_ok", 32'(resp_ok), 32'(ok));
            check("resp_code", 32'(resp_code), 32'(code));
            check("resp_lat", 32'(resp_lat), 32'(lat));
            check("ready_in_resp", 32'(req_ready), 32'd0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 32'(resp_valid), 32'd1);
                check("hold_fields", {resp_ok, resp_code, resp_lat},
                      {ok, code, lat});
            end
            resp_ready = 1'b1;
            @(posedge clk);
            #1;
            resp_ready = 1'b0;
            check("resp_drop", 32'(resp_valid), 32'd0);
            check("ready_after", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_vec    = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_drv", 32'(drv_vec), 32'd0);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_rready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("pre_edge_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // rising settle, then falling settle
        send(4'b1111);
        get_resp(1'b1, 2'd0, 5'd5, 8, 0);
        send(4'b0111);
        get_resp(1'b1, 2'd0, 5'd5, 8, 0);
        repeat (3) @(negedge clk);
        check("drv_idle_hold", 32'(drv_vec), 32'b0111);

        // tree output stuck low
        z_force_en  = 1'b1;
        z_force_val = 1'b0;
        send(4'b1111);
        get_resp(1'b0, 2'd1, 5'd16, 17, 0);

        // one-cycle pulse then stuck low
        send(4'b1111);
        @(negedge clk);
        @(negedge clk);
        z_force_val = 1'b1;
        @(negedge clk);
        z_force_val = 1'b0;
        get_resp(1'b0, 2'd2, 5'd16, 17, 0);

`ifdef AND_TREE_STIM_CTRL_STATS_EN
        check("stat_pass", 32'(stat_pass), 32'd2);
        check("stat_fail", 32'(stat_fail), 32'd2);
        check("stat_glitch", 32'(stat_glitch), 32'd1);
`endif

        // repeated vector already satisfied, response held 5 cycles
        z_force_en = 1'b0;
        repeat (4) @(negedge clk);
        send(4'b1111);
        get_resp(1'b1, 2'd0, 5'd0, 3, 5);

        // reset while waiting
        z_force_en  = 1'b1;
        z_force_val = 1'b0;
        send(4'b1111);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_drv", 32'(drv_vec), 32'd0);
        check("midrst_rvalid", 32'(resp_valid), 32'd0);
        check("midrst_rready", 32'(req_ready), 32'd0);
`ifdef AND_TREE_STIM_CTRL_STATS_EN
        check("midrst_stat", 32'(stat_pass), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        last_vec = '0;
        @(posedge clk);
        #1;
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_drv_hold", 32'(drv_vec), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
